alu_exec_stage: RTL and testbench

- Execute-stage ALU. Consumes the 4-bit ALU control code from the ALU control decoder, plus operands and shift amount from the ID/EX path.
- Produces a registered result with zero and overflow flags toward EX/MEM.
- Valid/ready handshake on both sides, with backpressure and flush for hazard handling.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_exec_stage_if.sv | 28 ++
 rtl/alu_shift_unit.sv | 78 +++++++
 rtl/alu_exec_stage.sv | 146 ++++++++++++++
 tb/tb_alu_exec_stage.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: op codes, datapath width, stage FSM states.
// ALU_SERIAL_SHIFT_EN adds the SHIFT state used by the iterative shifter.
package alu_pkg;

  localparam int ALU_WIDTH   = 32;
  localparam int SHAMT_WIDTH = 5;

  // Must match the ALU control decoder encoding bit for bit.
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE
    , ST_FULL
`ifdef ALU_SERIAL_SHIFT_EN
    , ST_SHIFT
`endif
  } stage_state_e;

  function automatic logic is_shift_op(input logic [3:0] ctr);
    return (ctr == ALU_SLL) || (ctr == ALU_SRL) || (ctr == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_exec_stage_if.sv
// Valid/ready operand and result bus between ID/EX, the execute ALU and EX/MEM.
// master = environment side (ID/EX + EX/MEM), slave = the execute stage.
interface alu_exec_stage_if #(
  parameter int WIDTH = alu_pkg::ALU_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_ctr;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [4:0]       shamt;
  logic             ovf_en;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, alu_ctr, src_a, src_b, shamt, ovf_en, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, alu_ctr, src_a, src_b, shamt, ovf_en, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_shift_unit.sv
// Shifter for SLL/SRL/SRA: log-stage barrel shifter by default, or a 1-bit-per-cycle
// iterative shifter with a step counter when ALU_SERIAL_SHIFT_EN is defined.
module alu_shift_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,   // shift op accepted this cycle
  input  logic             active,  // stage is in SHIFT, advance one step
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] value,
  input  logic [4:0]       shamt,
  output logic             last,    // final step happens this cycle
  output logic [WIDTH-1:0] result
);

`ifdef ALU_SERIAL_SHIFT_EN

  logic [WIDTH-1:0] val_reg;
  logic [WIDTH-1:0] val_next;
  logic [4:0]       cnt_reg;
  logic [3:0]       op_reg;

  always_comb begin
    if (op_reg == ALU_SLL) begin
      val_next = {val_reg[WIDTH-2:0], 1'b0};
    end else begin
      val_next = {(op_reg == ALU_SRA) & val_reg[WIDTH-1], val_reg[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      val_reg <= '0;
      cnt_reg <= '0;
      op_reg  <= ALU_ADD;
    end else if (start) begin
      val_reg <= value;
      cnt_reg <= shamt;
      op_reg  <= op;
    end else if (active) begin
      val_reg <= val_next;
      cnt_reg <= cnt_reg - 5'd1;
    end
  end

  assign last   = active && (cnt_reg == 5'd1);
  // Outside SHIFT only shamt==0 shifts complete directly, and they pass value through.
  assign result = active ? val_next : value;

`else

  logic             left;
  logic             fill;
  logic [WIDTH-1:0] stage [0:SHAMT_WIDTH];

  assign left     = (op == ALU_SLL);
  assign fill     = (op == ALU_SRA) & value[WIDTH-1];
  assign stage[0] = value;

  for (genvar gi = 0; gi < SHAMT_WIDTH; gi++) begin : g_stage
    localparam int S = 1 << gi;
    assign stage[gi+1] = !shamt[gi] ? stage[gi] :
                         left       ? {stage[gi][WIDTH-1-S:0], {S{1'b0}}} :
                                      {{S{fill}}, stage[gi][WIDTH-1:S]};
  end

  assign result = stage[SHAMT_WIDTH];
  assign last   = 1'b0;

  logic unused_inputs;
  assign unused_inputs = ^{clk, rst, start, active};

`endif

endmodule

// File: rtl/alu_exec_stage.sv
// Execute-stage ALU with registered result/zero/overflow and valid/ready on both sides.
// Optional ALU_SERIAL_SHIFT_EN build: shifts run through an iterative shifter (SHIFT state).
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH  // only 32 is supported (shamt is 5 bits)
) (
  input logic              clk,
  input logic              rst,
  input logic              flush,
  alu_exec_stage_if.slave  bus
);

  stage_state_e     state_reg;
  logic             out_valid_reg;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg;
  logic             overflow_reg;

  logic             in_ready;
  logic             accept;
  logic             is_shift;
  logic             enter_shift;
  logic             shift_active;
  logic             shift_last;
  logic [WIDTH-1:0] shift_result;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] alu_result;
  logic             alu_ovf;

  always_comb begin
    in_ready = !flush && (!out_valid_reg || bus.out_ready);
`ifdef ALU_SERIAL_SHIFT_EN
    if (state_reg == ST_SHIFT) in_ready = 1'b0;
`endif
  end

  assign accept   = bus.in_valid && in_ready;
  assign is_shift = is_shift_op(bus.alu_ctr);

`ifdef ALU_SERIAL_SHIFT_EN
  assign enter_shift  = is_shift && (bus.shamt != 5'd0);
  assign shift_active = (state_reg == ST_SHIFT);
`else
  assign enter_shift  = 1'b0;
  assign shift_active = 1'b0;
  logic unused_shift;
  assign unused_shift = shift_last;
`endif

  alu_shift_unit #(.WIDTH(WIDTH)) u_shift (
    .clk    (clk),
    .rst    (rst),
    .start  (accept && is_shift),
    .active (shift_active),
    .op     (bus.alu_ctr),
    .value  (bus.src_b),
    .shamt  (bus.shamt),
    .last   (shift_last),
    .result (shift_result)
  );

  assign sum  = bus.src_a + bus.src_b;
  assign diff = bus.src_a - bus.src_b;

  // Unused codes fall to the default: result 0, no overflow, still a normal completion.
  always_comb begin
    alu_result = '0;
    alu_ovf    = 1'b0;
    case (bus.alu_ctr)
      ALU_ADD: begin
        alu_result = sum;
        alu_ovf    = bus.ovf_en && (bus.src_a[WIDTH-1] == bus.src_b[WIDTH-1])
                                && (sum[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_result = diff;
        alu_ovf    = bus.ovf_en && (bus.src_a[WIDTH-1] != bus.src_b[WIDTH-1])
                                && (diff[WIDTH-1] != bus.src_a[WIDTH-1]);
      end
      ALU_AND:  alu_result = bus.src_a & bus.src_b;
      ALU_OR:   alu_result = bus.src_a | bus.src_b;
      ALU_NOR:  alu_result = ~(bus.src_a | bus.src_b);
      ALU_XOR:  alu_result = bus.src_a ^ bus.src_b;
      ALU_SLT:  alu_result = {{(WIDTH-1){1'b0}}, $signed(bus.src_a) < $signed(bus.src_b)};
      ALU_SLTU: alu_result = {{(WIDTH-1){1'b0}}, bus.src_a < bus.src_b};
      ALU_SLL, ALU_SRL, ALU_SRA: alu_result = shift_result;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
      result_reg    <= '0;
      zero_reg      <= 1'b0;
      overflow_reg  <= 1'b0;
    end else if (flush) begin
      // Result/flag registers keep stale contents; out_valid gates them.
      state_reg     <= ST_IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
`ifdef ALU_SERIAL_SHIFT_EN
        ST_SHIFT: begin
          if (shift_last) begin
            state_reg     <= ST_FULL;
            out_valid_reg <= 1'b1;
            result_reg    <= shift_result;
            zero_reg      <= (shift_result == '0);
            overflow_reg  <= 1'b0;
          end
        end
`endif
        default: begin
          if (accept) begin
            if (enter_shift) begin
`ifdef ALU_SERIAL_SHIFT_EN
              state_reg <= ST_SHIFT;
`endif
              out_valid_reg <= 1'b0;
            end else begin
              state_reg     <= ST_FULL;
              out_valid_reg <= 1'b1;
              result_reg    <= alu_result;
              zero_reg      <= (alu_result == '0);
              overflow_reg  <= alu_ovf;
            end
          end else if (out_valid_reg && bus.out_ready) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.zero      = zero_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed vector table, handshake corner sequences,
// and randomized traffic scored against a plain-arithmetic reference model.
module tb_alu_exec_stage;

`ifdef ALU_SERIAL_SHIFT_EN
  localparam bit SERIAL = 1'b1;
`else
  localparam bit SERIAL = 1'b0;
`endif

  localparam logic [3:0] C_ADD = 4'h0, C_SUB = 4'h1, C_AND = 4'h2, C_OR = 4'h3,
                         C_NOR = 4'h4, C_XOR = 4'h5, C_SLT = 4'h6, C_SLTU = 4'h7,
                         C_SLL = 4'h8, C_SRL = 4'h9, C_SRA = 4'hA;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  alu_exec_stage_if #(.WIDTH(32)) bus ();

  alu_exec_stage #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [3:0]  ctr;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic        oe;
    logic [31:0] res;
    logic        z;
    logic        o;
  } vec_t;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
  } exp_t;

  exp_t q[$];

  function automatic vec_t mk(string n, logic [3:0] c, logic [31:0] a, logic [31:0] b,
                              logic [4:0] sh, logic oe, logic [31:0] res, logic z, logic o);
    vec_t v;
    v.name = n; v.ctr = c; v.a = a; v.b = b; v.sh = sh; v.oe = oe;
    v.res = res; v.z = z; v.o = o;
    return v;
  endfunction

  // Reference: results from the op definitions using wide signed arithmetic.
  function automatic exp_t ref_alu(logic [3:0] c, logic [31:0] a, logic [31:0] b,
                                   logic [4:0] sh, logic oe);
    exp_t   r;
    longint sa;
    longint sb;
    longint full;
    longint trunc;
    sa = $signed(a);
    sb = $signed(b);
    r.res = 32'd0;
    r.o = 1'b0;
    case (c)
      C_ADD, C_SUB: begin
        full  = (c == C_ADD) ? sa + sb : sa - sb;
        r.res = full[31:0];
        trunc = $signed(full[31:0]);
        r.o   = oe && (full != trunc);
      end
      C_AND:  r.res = a & b;
      C_OR:   r.res = a | b;
      C_NOR:  r.res = ~(a | b);
      C_XOR:  r.res = a ^ b;
      C_SLT:  r.res = (sa < sb) ? 32'd1 : 32'd0;
      C_SLTU: r.res = (a < b) ? 32'd1 : 32'd0;
      C_SLL:  r.res = b << sh;
      C_SRL:  r.res = b >> sh;
      C_SRA:  r.res = $signed(b) >>> sh;
      default: r.res = 32'd0;
    endcase
    r.z = (r.res == 32'd0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op through an idle stage with out_ready=1; checks latency and in_ready gap too.
  task automatic run_vec(input vec_t v);
    int lat;
    int low;
    int exp_lat;
    bus.alu_ctr = v.ctr; bus.src_a = v.a; bus.src_b = v.b;
    bus.shamt = v.sh; bus.ovf_en = v.oe;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    check({v.name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    low = 0;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.in_ready) low++;
      tick();
      lat++;
    end
    exp_lat = (SERIAL && (v.ctr inside {C_SLL, C_SRL, C_SRA}) && v.sh != 0) ? int'(v.sh) + 1 : 1;
    check({v.name, "_latency"}, 32'(lat), 32'(exp_lat));
    check({v.name, "_busy_cycles"}, 32'(low), 32'(exp_lat - 1));
    check({v.name, "_result"}, bus.result, v.res);
    check({v.name, "_zero"}, 32'(bus.zero), 32'(v.z));
    check({v.name, "_overflow"}, 32'(bus.overflow), 32'(v.o));
    $display("txn %-12s ctr=%h a=%08h b=%08h sh=%0d -> res=%08h z=%0b o=%0b lat=%0d",
             v.name, v.ctr, v.a, v.b, v.sh, bus.result, bus.zero, bus.overflow, lat);
    tick();
    check({v.name, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[14];
    int   seen;
    exp_t e;

    vecs[0]  = mk("add_ovf",   C_ADD,  32'h7FFFFFFF, 32'h1,        5'd0,  1'b1, 32'h80000000, 1'b0, 1'b1);
    vecs[1]  = mk("add_noovf", C_ADD,  32'h7FFFFFFF, 32'h1,        5'd0,  1'b0, 32'h80000000, 1'b0, 1'b0);
    vecs[2]  = mk("sub_zero",  C_SUB,  32'h12345678, 32'h12345678, 5'd0,  1'b1, 32'h0,        1'b1, 1'b0);
    vecs[3]  = mk("sub_ovf",   C_SUB,  32'h80000000, 32'h1,        5'd0,  1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
    vecs[4]  = mk("slt",       C_SLT,  32'hFFFFFFFF, 32'h1,        5'd0,  1'b0, 32'h1,        1'b0, 1'b0);
    vecs[5]  = mk("sltu",      C_SLTU, 32'hFFFFFFFF, 32'h1,        5'd0,  1'b0, 32'h0,        1'b1, 1'b0);
    vecs[6]  = mk("sra4",      C_SRA,  32'h0,        32'h80000000, 5'd4,  1'b0, 32'hF8000000, 1'b0, 1'b0);
    vecs[7]  = mk("srl4",      C_SRL,  32'h0,        32'h80000000, 5'd4,  1'b0, 32'h08000000, 1'b0, 1'b0);
    vecs[8]  = mk("sll31",     C_SLL,  32'h0,        32'h00000001, 5'd31, 1'b0, 32'h80000000, 1'b0, 1'b0);
    vecs[9]  = mk("sra0",      C_SRA,  32'h0,        32'h80000001, 5'd0,  1'b0, 32'h80000001, 1'b0, 1'b0);
    vecs[10] = mk("nor",       C_NOR,  32'h0,        32'h0,        5'd0,  1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[11] = mk("xor",       C_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  1'b0, 32'h0FF00FF0, 1'b0, 1'b0);
    vecs[12] = mk("and",       C_AND,  32'hFF00FF00, 32'h0F0F0F0F, 5'd0,  1'b0, 32'h0F000F00, 1'b0, 1'b0);
    vecs[13] = mk("code1101",  4'hD,   32'h5,        32'h7,        5'd0,  1'b1, 32'h0,        1'b1, 1'b0);

    bus.in_valid = 1'b0; bus.alu_ctr = 4'h0; bus.src_a = 32'h0; bus.src_b = 32'h0;
    bus.shamt = 5'd0; bus.ovf_en = 1'b0; bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_result", bus.result, 32'h0);
    check("reset_zero", 32'(bus.zero), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
    check("reset_in_ready", 32'(bus.in_ready), 32'd1);

    for (int i = 0; i < 14; i++) run_vec(vecs[i]);

    // Backpressure: held result stays put, then two ops drain with no bubble.
    bus.alu_ctr = C_ADD; bus.src_a = 32'd10; bus.src_b = 32'd20; bus.ovf_en = 1'b0;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.src_a = 32'd1; bus.src_b = 32'd2;
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_result_stable", bus.result, 32'd30);
      check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
      tick();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_on_drain", 32'(bus.in_ready), 32'd1);
    tick();
    check("b2b_first_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_first_result", bus.result, 32'd3);
    bus.alu_ctr = C_OR; bus.src_a = 32'hF0; bus.src_b = 32'h0F;
    check("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("b2b_second_valid", 32'(bus.out_valid), 32'd1);
    check("b2b_second_result", bus.result, 32'hFF);
    $display("txn backpressure  drained 30, 3, 0xFF");
    bus.in_valid = 1'b0;
    tick();
    check("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Flush while FULL: held op killed, op presented during flush is not taken.
    bus.alu_ctr = C_ADD; bus.src_a = 32'd5; bus.src_b = 32'd6;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    check("flush_pre_valid", 32'(bus.out_valid), 32'd1);
    bus.src_a = 32'd100; bus.src_b = 32'd100;
    flush = 1'b1;
    #1;
    check("flush_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("flush_clears_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("flush_no_accept", 32'(bus.out_valid), 32'd0);
    $display("txn flush_full    held op discarded");
    run_vec(mk("after_flush", C_ADD, 32'd7, 32'd8, 5'd0, 1'b0, 32'd15, 1'b0, 1'b0));

`ifdef ALU_SERIAL_SHIFT_EN
    // Flush in the middle of a 10-step shift: nothing may come out.
    bus.alu_ctr = C_SLL; bus.src_b = 32'h1; bus.shamt = 5'd10;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("shift_busy", 32'(bus.in_ready), 32'd0);
    tick();
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("shift_flush_valid", 32'(bus.out_valid), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) seen++;
      tick();
    end
    check("shift_flush_no_stale", 32'(seen), 32'd0);
    $display("txn flush_shift   shift aborted");
    run_vec(mk("after_sflush", C_OR, 32'h1, 32'h2, 5'd0, 1'b0, 32'h3, 1'b0, 1'b0));
`endif

    // Reset mid-stream, with flush also high: reset must still clear the result.
    bus.alu_ctr = C_ADD; bus.src_a = 32'h7FFFFFFF; bus.src_b = 32'h1; bus.ovf_en = 1'b1;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    check("rst_pre_overflow", 32'(bus.overflow), 32'd1);
    rst = 1'b1;
    flush = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_result", bus.result, 32'h0);
    check("rst_mid_zero", 32'(bus.zero), 32'd0);
    check("rst_mid_overflow", 32'(bus.overflow), 32'd0);
    $display("txn reset_mid     outputs cleared");

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.alu_ctr  = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: bus.src_a = 32'h7FFFFFFF;
        1: bus.src_a = 32'h80000000;
        default: bus.src_a = $urandom;
      endcase
      bus.src_b  = ($urandom_range(0, 5) == 0) ? bus.src_a : $urandom;
      bus.shamt  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      bus.ovf_en = 1'($urandom_range(0, 1));
      flush = ($urandom_range(0, 29) == 0);
      bus.out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (flush) begin
        q.delete();
      end else begin
        if (bus.out_valid && bus.out_ready) begin
          check("rnd_expected_pending", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("rnd_result", bus.result, e.res);
            check("rnd_zero", 32'(bus.zero), 32'(e.z));
            check("rnd_overflow", 32'(bus.overflow), 32'(e.o));
            $display("txn rnd %0d res=%08h z=%0b o=%0b", i, bus.result, bus.zero, bus.overflow);
          end
        end
        if (bus.in_valid && bus.in_ready)
          q.push_back(ref_alu(bus.alu_ctr, bus.src_a, bus.src_b, bus.shamt, bus.ovf_en));
      end
      tick();
    end

    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 60 && q.size() != 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        e = q.pop_front();
        check("rnd_drain_result", bus.result, e.res);
        check("rnd_drain_zero", 32'(bus.zero), 32'(e.z));
        check("rnd_drain_overflow", 32'(bus.overflow), 32'(e.o));
        $display("txn drain res=%08h z=%0b o=%0b", bus.result, bus.zero, bus.overflow);
      end
      tick();
    end
    check("rnd_queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
